// File: rtl/gpu_frame_sequencer.sv
// Vertex-stream loader and frame sequencer for GPU_top: writes the stream into
// vertex memory, then issues start pulses and counts frame_end rising edges.
`timescale 1ns/1ps
module gpu_frame_sequencer #(
  parameter int unsigned M                = 11,
  parameter int unsigned N                = 7,
  parameter int unsigned VERTEX_MEM_DEPTH = 16384,
  parameter int unsigned FRAME_CNT_W      = 16,
  localparam int unsigned W               = M + N,
  localparam int unsigned A               = $clog2(VERTEX_MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [W-1:0]           s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   go,
  input  logic                   abort,
  input  logic [FRAME_CNT_W-1:0] cfg_frames,
  input  logic [31:0]            cfg_gap,
  output logic [A-1:0]           mem_wr_addr,
  output logic [W-1:0]           mem_wr_data,
  output logic                   mem_wr_en,
  output logic [31:0]            vertex_count,
  output logic                   gpu_start,
  input  logic                   gpu_frame_end,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [FRAME_CNT_W-1:0] frames_done
);

  localparam logic [A-1:0] LAST_IDX  = A'(VERTEX_MEM_DEPTH - 1);
  localparam logic [31:0]  DEPTH_CNT = 32'(VERTEX_MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_GAP, S_START, S_WAIT_FRAME, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [A-1:0]           idx_q, idx_d;
  logic                   wr_en_q, wr_en_d;
  logic [A-1:0]           wr_addr_q, wr_addr_d;
  logic [W-1:0]           wr_data_q, wr_data_d;
  logic [31:0]            vcount_q, vcount_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;
  logic                   ovf_q, ovf_d;
  logic [31:0]            gap_q, gap_d;
  logic                   fe_prev_q;
  logic [1:0]             rst_sync_q;
  logic                   rst_n;

  logic                   accept;
  logic                   fe_edge;
  logic [FRAME_CNT_W-1:0] frames_inc;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign s_ready    = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !abort;
  assign accept     = s_valid && s_ready;
  assign fe_edge    = gpu_frame_end && !fe_prev_q;
  assign frames_inc = frames_q + FRAME_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      vcount_q  <= '0;
      frames_q  <= '0;
      ovf_q     <= 1'b0;
      gap_q     <= '0;
      fe_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      vcount_q  <= vcount_d;
      frames_q  <= frames_d;
      ovf_q     <= ovf_d;
      gap_q     <= gap_d;
      fe_prev_q <= gpu_frame_end;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    vcount_d  = vcount_q;
    frames_d  = frames_q;
    ovf_d     = ovf_q;
    gap_d     = gap_q;

    // abort outranks every other event in the same cycle
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d  = S_LOAD;
            idx_d    = '0;
            frames_d = '0;
            ovf_d    = 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = s_data;
            if (s_last) begin
              vcount_d = 32'(idx_q) + 32'd1;
              if (cfg_gap == 32'd0) begin
                state_d = S_START;
              end else begin
                state_d = S_GAP;
                gap_d   = cfg_gap;
              end
            end else if (idx_q == LAST_IDX) begin
              ovf_d   = 1'b1;
              state_d = S_DRAIN;
            end else begin
              idx_d = idx_q + A'(1);
            end
          end
        end
        S_DRAIN: begin
          if (accept && s_last) begin
            vcount_d = DEPTH_CNT;
            state_d  = S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_q <= 32'd1) state_d = S_START;
          else                gap_d   = gap_q - 32'd1;
        end
        S_START: begin
          state_d = S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (fe_edge) begin
            frames_d = frames_inc;
            if ((cfg_frames != '0) && (frames_inc == cfg_frames)) begin
              state_d = S_DONE;
            end else if (cfg_gap == 32'd0) begin
              state_d = S_START;
            end else begin
              state_d = S_GAP;
              gap_d   = cfg_gap;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign gpu_start    = (state_q == S_START) && !abort;
  assign done         = (state_q == S_DONE) && !abort;
  assign mem_wr_en    = wr_en_q && !abort;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign vertex_count = vcount_q;
  assign frames_done  = frames_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/gpu_frame_sequencer.md
Name: gpu_frame_sequencer

Overview:
Synthesizable replacement for the bench-side load/start/capture sequence around GPU_top. Accepts a vertex word stream and writes it into the GPU vertex memory through its write port. It then issues start pulses, waits for each frame_end, and repeats for a programmed frame count or continuously. Sits between the PS/DMA stream and GPU_top.

Parameters:
M, 11, integer bits of vertex word
N, 7, fractional bits of vertex word; word width W = M+N
VERTEX_MEM_DEPTH, 16384, vertex memory depth; address width A = $clog2(VERTEX_MEM_DEPTH)
FRAME_CNT_W, 16, width of frame counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
s_data  in  W  vertex word
s_valid  in  1  stream valid
s_last  in  1  marks final vertex word
s_ready  out  1  stream ready
go  in  1  single-cycle command: load, then run
abort  in  1  return to IDLE
cfg_frames  in  FRAME_CNT_W  frames to render; 0 = continuous
cfg_gap  in  32  idle cycles before each start
mem_wr_addr  out  A  vertex memory write address
mem_wr_data  out  W  vertex memory write data
mem_wr_en  out  1  vertex memory write enable
vertex_count  out  32  words loaded
gpu_start  out  1  single-cycle start pulse to GPU_top
gpu_frame_end  in  1  frame_end from GPU_top (level)
busy  out  1  state != IDLE
done  out  1  single-cycle pulse after last programmed frame
overflow  out  1  sticky: stream exceeded VERTEX_MEM_DEPTH
frames_done  out  FRAME_CNT_W  frames completed since last go

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE. All outputs 0 (mem_wr_addr=0, vertex_count=0, frames_done=0, overflow=0). Previous frame_end sample = 0.
- States: IDLE, LOAD, DRAIN, GAP, START, WAIT_FRAME, DONE.
- IDLE: s_ready=0. go -> LOAD; clears frames_done, overflow and the word counter. go outside IDLE is ignored.
- LOAD: s_ready=1. A beat is accepted when s_valid&s_ready. Writes are registered: a beat accepted in cycle k gives mem_wr_en=1 in k+1, with mem_wr_addr=index and mem_wr_data=s_data. Index starts at 0 and increments per beat.
- LOAD exit, s_last accepted at index i: vertex_count=i+1 in the next cycle, then -> GAP. A single-beat load gives vertex_count=1.
- LOAD overflow: if a beat is accepted at index VERTEX_MEM_DEPTH-1 without s_last, set overflow and go to DRAIN. The address never wraps.
- DRAIN: s_ready=1 and beats are discarded (no write) until s_last is accepted. Then -> IDLE with vertex_count=VERTEX_MEM_DEPTH and no frames issued.
- GAP: counter loaded with cfg_gap on entry; counts down and moves to START when it reaches 0. Total GAP dwell = cfg_gap cycles. If cfg_gap=0, GAP is skipped and START follows the transition cycle directly.
- START: gpu_start=1 for exactly one cycle -> WAIT_FRAME.
- WAIT_FRAME: waits for a rising edge of gpu_frame_end (current 1, previous sample 0).
  - On the edge, frames_done increments.
  - If cfg_frames!=0 and the new frames_done==cfg_frames -> DONE; otherwise -> GAP.
  - Vertices are not reloaded between frames.
- DONE: done=1 for one cycle -> IDLE.
- frames_done wraps modulo 2^FRAME_CNT_W in continuous mode.
- gpu_frame_end edges outside WAIT_FRAME are ignored, but the edge detector always samples.
- abort, any state: -> IDLE next cycle. gpu_start, mem_wr_en, done and s_ready are forced 0 that cycle. vertex_count and frames_done are retained.
- abort has priority over go, s_last and a frame_end edge in the same cycle; that edge is not counted.
- cfg_frames and cfg_gap are sampled on each entry to GAP/WAIT_FRAME decisions; changes take effect at the next decision.
- busy is combinational from state.

Test Plan:
- Load 5 words (s_last on 5th), cfg_gap=3, cfg_frames=1 -> writes to addresses 0..4 with matching data, one cycle after each accepted beat. vertex_count=5. gpu_start 3 cycles after GAP entry. A frame_end pulse gives frames_done=1, a done pulse, then IDLE.
- s_valid toggling (valid 1,0,1,1,0,1, last on the 4th beat) -> exactly 4 writes at addresses 0..3; no write on idle cycles.
- VERTEX_MEM_DEPTH=8, stream 10 words -> writes to addresses 0..7, overflow=1, words 9-10 drained with no writes, return to IDLE, gpu_start never asserted.
- cfg_frames=0, cfg_gap=0, model GPU asserts frame_end 20 cycles after each start -> start pulses repeat. frames_done reaches 4 after 4 edges; a held-high frame_end counts once.
- abort in WAIT_FRAME on the same cycle as a frame_end edge -> IDLE, frames_done unchanged, no done pulse. A subsequent go reloads from address 0.
- Assert reset_n=0 mid-LOAD, asynchronously between clock edges -> all outputs 0 immediately. State is IDLE after release.
